// File: rtl/int_pkg.sv
// Shared definitions for the prioritised interrupt manager: FSM encoding,
// default vector table placement and the vector address helper.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } int_state_e;

  localparam int unsigned DEF_VEC_BASE   = 32'h3C0;
  localparam int unsigned DEF_VEC_STRIDE = 8;

  // ISR start address of a channel before truncation to the PC width.
  function automatic int unsigned vec_addr(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned idx);
    return base + stride * idx;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: idx is the lowest set bit of req,
// any flags that at least one request is present.
module prio_enc #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IW  = 4
) (
  input  logic [NCH-1:0] req,
  output logic [IW-1:0]  idx,
  output logic           any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req[NCH-1-i]) idx = IW'(NCH-1-i);
    end
  end

endmodule

// File: rtl/gest_interrup_prio.sv
// Parametrised interrupt manager: per-channel rising-edge capture, pending
// latch, mask and sticky overrun, fixed-priority arbitration and the
// request/acknowledge/end-of-service handshake with the control unit.
module gest_interrup_prio
  import int_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned VW         = 10,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int unsigned IW         = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq,
  input  logic           gie,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_in,
  input  logic [NCH-1:0] ovr_clr,
  input  logic           int_ack,
  input  logic           fin_interrup,
  output logic           int_req,
  output logic [VW-1:0]  vector,
  output logic [IW-1:0]  active_id,
  output logic           in_service,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] mask,
  output logic [NCH-1:0] overrun
);

  logic [NCH-1:0] irq_d_q, irq_d_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  int_state_e     state_q, state_d;
  logic           int_req_q, int_req_d;
  logic [VW-1:0]  vector_q, vector_d;
  logic [IW-1:0]  active_id_q, active_id_d;
  logic           in_service_q, in_service_d;

  logic [NCH-1:0] rise;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] act_onehot;
  logic [NCH-1:0] pend_clr;
  logic [IW-1:0]  win_idx;
  logic           win_any;

  prio_enc #(
    .NCH (NCH),
    .IW  (IW)
  ) u_prio_enc (
    .req (elig),
    .idx (win_idx),
    .any (win_any)
  );

  // Decode the frozen active channel into a one-hot for clearing and mask tests.
  always_comb begin
    act_onehot = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (active_id_q == IW'(i)) act_onehot[i] = 1'b1;
    end
  end

  // Edge capture, pending/overrun update and mask register next state.
  always_comb begin
    irq_d_d   = irq;
    rise      = irq & ~irq_d_q;
    pend_clr  = (state_q == REQ && int_ack) ? act_onehot : '0;
    // Set is ORed after the clear so a same-cycle event keeps the latch high.
    pending_d = (pending_q & ~pend_clr) | rise;
    overrun_d = (overrun_q & ~ovr_clr) | (rise & pending_q);
    mask_d    = mask_we ? mask_in : mask_q;
    elig      = gie ? (pending_q & mask_q) : '0;
  end

  // Handshake FSM next state; outputs are registered alongside the state.
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d     = REQ;
          int_req_d   = 1'b1;
          active_id_d = win_idx;
          vector_d    = VW'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(win_idx)));
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a simultaneous withdrawal.
        if (int_ack) begin
          state_d      = SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end else if (!gie || ((mask_q & act_onehot) == '0)) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      SERVICE: begin
        if (fin_interrup) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      overrun_q <= '0;
    end else begin
      irq_d_q   <= irq_d_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      vector_q     <= '0;
      active_id_q  <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign vector     = vector_q;
  assign active_id  = active_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_gest_interrup_prio.sv
// Directed bench for gest_interrup_prio with hand-computed expectations.
module tb_gest_interrup_prio;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       gie;
  logic       mask_we;
  logic [3:0] mask_in;
  logic [3:0] ovr_clr;
  logic       int_ack;
  logic       fin_interrup;
  logic       int_req;
  logic [9:0] vector;
  logic [3:0] active_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] overrun;

  int n_checks = 0;
  int n_fail   = 0;

  gest_interrup_prio #(
    .NCH        (4),
    .VW         (10),
    .VEC_BASE   (32'h3C0),
    .VEC_STRIDE (8),
    .IW         (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .gie          (gie),
    .mask_we      (mask_we),
    .mask_in      (mask_in),
    .ovr_clr      (ovr_clr),
    .int_ack      (int_ack),
    .fin_interrup (fin_interrup),
    .int_req      (int_req),
    .vector       (vector),
    .active_id    (active_id),
    .in_service   (in_service),
    .pending      (pending),
    .mask         (mask),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = '0; gie = 1'b0; mask_we = 1'b0; mask_in = '0;
    ovr_clr = '0; int_ack = 1'b0; fin_interrup = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({int_req, in_service, vector, active_id, pending, mask, overrun} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b svc=%b vec=%h id=%h pend=%b mask=%b ovr=%b, want all 0",
               int_req, in_service, vector, active_id, pending, mask, overrun);
    end
  endtask

  task automatic test_basic();
    gie = 1'b1; mask_we = 1'b1; mask_in = 4'hF;
    step();
    mask_we = 1'b0;
    n_checks++;
    if (mask !== 4'hF) begin n_fail++; $display("FAIL mask_load: got %b want 1111", mask); end
    irq = 4'b0100;
    step();
    irq = '0;
    n_checks++;
    if (pending !== 4'b0100 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_pending: got pend=%b req=%b want 0100/0", pending, int_req);
    end
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3D0 || active_id !== 4'd2) begin
      n_fail++; $display("FAIL basic_req: got req=%b vec=%h id=%0d want 1/3d0/2", int_req, vector, active_id);
    end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    n_checks++;
    if (pending !== 4'b0000 || in_service !== 1'b1 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_ack: got pend=%b svc=%b req=%b want 0000/1/0", pending, in_service, int_req);
    end
    fin_interrup = 1'b1;
    step();
    fin_interrup = 1'b0;
    n_checks++;
    if (in_service !== 1'b0 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_fin: got svc=%b req=%b want 0/0", in_service, int_req);
    end
  endtask

  task automatic test_priority_freeze();
    irq = 4'b1010;
    step();
    irq = '0;
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3C8 || active_id !== 4'd1) begin
      n_fail++; $display("FAIL prio_ch1: got req=%b vec=%h id=%0d want 1/3c8/1", int_req, vector, active_id);
    end
    irq = 4'b0001;
    step();
    irq = '0;
    step();
    n_checks++;
    if (pending !== 4'b1011 || vector !== 10'h3C8 || active_id !== 4'd1 || int_req !== 1'b1) begin
      n_fail++; $display("FAIL prio_freeze: got pend=%b vec=%h id=%0d req=%b want 1011/3c8/1/1",
                         pending, vector, active_id, int_req);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    fin_interrup = 1'b1; step(); fin_interrup = 1'b0;
    n_checks++;
    if (int_req !== 1'b0 || pending !== 4'b1001) begin
      n_fail++; $display("FAIL prio_gap: got req=%b pend=%b want 0/1001", int_req, pending);
    end
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3C0 || active_id !== 4'd0) begin
      n_fail++; $display("FAIL prio_ch0: got req=%b vec=%h id=%0d want 1/3c0/0", int_req, vector, active_id);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    fin_interrup = 1'b1; step(); fin_interrup = 1'b0;
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3D8 || active_id !== 4'd3) begin
      n_fail++; $display("FAIL prio_ch3: got req=%b vec=%h id=%0d want 1/3d8/3", int_req, vector, active_id);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    fin_interrup = 1'b1; step(); fin_interrup = 1'b0;
    step();
  endtask

  task automatic test_masking();
    mask_we = 1'b1; mask_in = 4'b1110;
    step();
    mask_we = 1'b0;
    irq = 4'b0001;
    step();
    irq = '0;
    step(); step();
    n_checks++;
    if (pending !== 4'b0001 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL mask_block: got pend=%b req=%b want 0001/0", pending, int_req);
    end
    mask_we = 1'b1; mask_in = 4'hF;
    step();
    mask_we = 1'b0;
    n_checks++;
    if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_early: got req=%b want 0", int_req); end
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3C0) begin
      n_fail++; $display("FAIL mask_unblock: got req=%b vec=%h want 1/3c0", int_req, vector);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    fin_interrup = 1'b1; step(); fin_interrup = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    irq = 4'b0010;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (pending !== 4'b0010 || overrun !== 4'b0000 || int_req !== 1'b1 || active_id !== 4'd1) begin
      n_fail++; $display("FAIL stuck_level: got pend=%b ovr=%b req=%b id=%0d want 0010/0000/1/1",
                         pending, overrun, int_req, active_id);
    end
    irq = '0;
    step();
    irq = 4'b0010;
    step();
    irq = '0;
    n_checks++;
    if (overrun !== 4'b0010 || pending !== 4'b0010) begin
      n_fail++; $display("FAIL overrun_set: got ovr=%b pend=%b want 0010/0010", overrun, pending);
    end
    step();
    n_checks++;
    if (overrun !== 4'b0010) begin n_fail++; $display("FAIL overrun_sticky: got %b want 0010", overrun); end
    ovr_clr = 4'b0010;
    step();
    ovr_clr = '0;
    n_checks++;
    if (overrun !== 4'b0000) begin n_fail++; $display("FAIL overrun_clr: got %b want 0000", overrun); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    n_checks++;
    if (pending !== 4'b0000 || in_service !== 1'b1) begin
      n_fail++; $display("FAIL overrun_ack: got pend=%b svc=%b want 0000/1", pending, in_service);
    end
    fin_interrup = 1'b1; step(); fin_interrup = 1'b0;
    step();
  endtask

  task automatic test_withdrawal();
    irq = 4'b0100;
    step();
    irq = '0;
    step();
    n_checks++;
    if (int_req !== 1'b1 || active_id !== 4'd2) begin
      n_fail++; $display("FAIL wd_req: got req=%b id=%0d want 1/2", int_req, active_id);
    end
    gie = 1'b0;
    step();
    n_checks++;
    if (int_req !== 1'b0 || pending !== 4'b0100) begin
      n_fail++; $display("FAIL wd_drop: got req=%b pend=%b want 0/0100", int_req, pending);
    end
    gie = 1'b1;
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3D0) begin
      n_fail++; $display("FAIL wd_restore: got req=%b vec=%h want 1/3d0", int_req, vector);
    end
    // Ack and a new edge on the same channel in one cycle: the set survives.
    int_ack = 1'b1; irq = 4'b0100;
    step();
    int_ack = 1'b0;
    n_checks++;
    if (in_service !== 1'b1 || pending !== 4'b0100 || overrun !== 4'b0100) begin
      n_fail++; $display("FAIL set_wins: got svc=%b pend=%b ovr=%b want 1/0100/0100", in_service, pending, overrun);
    end
  endtask

  task automatic test_async_reset();
    irq = '0;
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({int_req, in_service, vector, active_id, pending, mask, overrun} !== 28'd0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b svc=%b vec=%h id=%h pend=%b mask=%b ovr=%b want all 0",
               int_req, in_service, vector, active_id, pending, mask, overrun);
    end
    step();
    #2;
    reset = 1'b1;
    mask_we = 1'b1; mask_in = 4'hF;
    step();
    mask_we = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet: got req=%b pend=%b svc=%b want 0/0000/0", int_req, pending, in_service);
    end
    irq = 4'b1000;
    step();
    irq = '0;
    step();
    n_checks++;
    if (int_req !== 1'b1 || vector !== 10'h3D8) begin
      n_fail++; $display("FAIL post_reset_req: got req=%b vec=%h want 1/3d8", int_req, vector);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority_freeze();
    test_masking();
    test_overrun();
    test_withdrawal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
